// File: rtl/cpu_pkg.sv
// cpu_pkg: shared ALU control codes, datapath defaults and the register-zero constant
package cpu_pkg;
  localparam int DW_DEF = 32;
  localparam int AW_DEF = 5;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_OR = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b110;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// fwd_sel: per-operand priority forwarding mux (held EX result, then stage ahead, then register file)
module fwd_sel import cpu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic [AW-1:0] src,
  input  logic          ex_fwd_en,
  input  logic [AW-1:0] ex_rd,
  input  logic [DW-1:0] alu_out,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic [DW-1:0] rf_data,
  output logic [DW-1:0] data
);
  logic nz;
  always_comb begin
    nz = src != AW'(REG_ZERO);
    data = (nz && ex_fwd_en && ex_rd == src) ? alu_out :
           (nz && mem_regwrite && mem_rd == src) ? mem_data : rf_data;
  end
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with capture-time forwarding and load-use bubble insertion
module id_ex_stage import cpu_pkg::*; #(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          id_valid,
  output logic          id_ready,
  input  logic [AW-1:0] id_rs,
  input  logic [AW-1:0] id_rt,
  input  logic [AW-1:0] id_rd,
  input  logic          id_uses_rs,
  input  logic          id_uses_rt,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic          id_alusrc,
  input  logic [2:0]    id_aluctr,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic [DW-1:0] alu_out,
  input  logic          mem_regwrite,
  input  logic [AW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  input  logic          ex_ready,
  output logic          ex_valid,
  output logic [DW-1:0] ex_a,
  output logic [DW-1:0] ex_b,
  output logic [DW-1:0] ex_st_data,
  output logic [2:0]    ex_aluctr,
  output logic [AW-1:0] ex_rd,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic [15:0]   stall_cnt
);
  logic          valid_q, valid_d;
  logic [DW-1:0] a_q, a_d, b_q, b_d, st_q, st_d;
  logic [2:0]    aluctr_q, aluctr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          regwrite_q, regwrite_d, memread_q, memread_d, memwrite_q, memwrite_d;
  logic [15:0]   stall_q, stall_d;
  logic          adv, lu, cap, kill, ex_fwd_en;
  logic [DW-1:0] fwd_rs, fwd_rt;
  fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rs (
    .src(id_rs), .ex_fwd_en(ex_fwd_en), .ex_rd(rd_q), .alu_out(alu_out),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_data(id_rs_data), .data(fwd_rs)
  );
  fwd_sel #(.DW(DW), .AW(AW)) u_fwd_rt (
    .src(id_rt), .ex_fwd_en(ex_fwd_en), .ex_rd(rd_q), .alu_out(alu_out),
    .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_data(mem_data),
    .rf_data(id_rt_data), .data(fwd_rt)
  );
  always_comb begin
    ex_fwd_en = valid_q & regwrite_q & ~memread_q;
    adv = ex_ready | ~valid_q;
    lu = valid_q & memread_q & (rd_q != AW'(REG_ZERO)) & id_valid &
         ((id_uses_rs & (id_rs == rd_q)) | (id_uses_rt & (id_rt == rd_q)));
    id_ready = ~rst & (flush | (adv & ~lu));
    kill = flush | (adv & lu);
    cap = adv & ~lu & ~flush;
    valid_d = kill ? 1'b0 : cap ? id_valid : valid_q;
    a_d = kill ? '0 : cap ? fwd_rs : a_q;
    b_d = kill ? '0 : cap ? (id_alusrc ? id_imm : fwd_rt) : b_q;
    st_d = kill ? '0 : cap ? fwd_rt : st_q;
    aluctr_d = kill ? '0 : cap ? id_aluctr : aluctr_q;
    rd_d = kill ? '0 : cap ? id_rd : rd_q;
    regwrite_d = kill ? 1'b0 : cap ? id_regwrite & (id_rd != AW'(REG_ZERO)) : regwrite_q;
    memread_d = kill ? 1'b0 : cap ? id_memread : memread_q;
    memwrite_d = kill ? 1'b0 : cap ? id_memwrite : memwrite_q;
    stall_d = (~flush & adv & lu & (stall_q != 16'hFFFF)) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      st_q <= '0;
      aluctr_q <= '0;
      rd_q <= '0;
      regwrite_q <= 1'b0;
      memread_q <= 1'b0;
      memwrite_q <= 1'b0;
      stall_q <= '0;
    end else begin
      valid_q <= valid_d;
      a_q <= a_d;
      b_q <= b_d;
      st_q <= st_d;
      aluctr_q <= aluctr_d;
      rd_q <= rd_d;
      regwrite_q <= regwrite_d;
      memread_q <= memread_d;
      memwrite_q <= memwrite_d;
      stall_q <= stall_d;
    end
  end
  assign ex_valid = valid_q;
  assign ex_a = a_q;
  assign ex_b = b_q;
  assign ex_st_data = st_q;
  assign ex_aluctr = aluctr_q;
  assign ex_rd = rd_q;
  assign ex_regwrite = regwrite_q;
  assign ex_memread = memread_q;
  assign ex_memwrite = memwrite_q;
  assign stall_cnt = stall_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage
module tb_id_ex_stage;
  import cpu_pkg::*;
  logic clk = 1'b0;
  logic rst, flush, id_valid, id_ready, id_uses_rs, id_uses_rt, id_alusrc;
  logic [4:0] id_rs, id_rt, id_rd, mem_rd, ex_rd;
  logic [31:0] id_rs_data, id_rt_data, id_imm, alu_out, mem_data, ex_a, ex_b, ex_st_data;
  logic [2:0] id_aluctr, ex_aluctr;
  logic id_regwrite, id_memread, id_memwrite, mem_regwrite, ex_ready;
  logic ex_valid, ex_regwrite, ex_memread, ex_memwrite;
  logic [15:0] stall_cnt;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(id_ready),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_alusrc(id_alusrc),
    .id_aluctr(id_aluctr), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .id_memwrite(id_memwrite), .alu_out(alu_out), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
    .mem_data(mem_data), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b),
    .ex_st_data(ex_st_data), .ex_aluctr(ex_aluctr), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .stall_cnt(stall_cnt)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_id(input logic [4:0] rs, rt, rd, input logic [31:0] rsd, rtd,
                        input logic [2:0] ctr, input logic rw, mr);
    id_valid = 1'b1;
    id_rs = rs;
    id_rt = rt;
    id_rd = rd;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_aluctr = ctr;
    id_regwrite = rw;
    id_memread = mr;
    id_memwrite = 1'b0;
    id_uses_rs = 1'b1;
    id_uses_rt = 1'b1;
    id_alusrc = 1'b0;
    id_imm = '0;
  endtask
  initial begin
    rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_rd = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_alusrc = 1'b0; id_aluctr = '0;
    id_regwrite = 1'b0; id_memread = 1'b0; id_memwrite = 1'b0;
    alu_out = '0; mem_regwrite = 1'b0; mem_rd = '0; mem_data = '0;
    tick();
    tick();
    chk("rst_id_ready", 32'(id_ready), 0);
    chk("rst_valid", 32'(ex_valid), 0);
    chk("rst_a", ex_a, 0);
    chk("rst_b", ex_b, 0);
    chk("rst_ctl", 32'({ex_regwrite, ex_memread, ex_memwrite, ex_rd, ex_aluctr}), 0);
    chk("rst_stall", 32'(stall_cnt), 0);
    rst = 1'b0;
    set_id(1, 2, 5, 32'h5, 32'h7, ALU_ADD, 1, 0);
    #1 chk("basic_ready", 32'(id_ready), 1);
    tick();
    chk("basic_valid", 32'(ex_valid), 1);
    chk("basic_a", ex_a, 32'h5);
    chk("basic_b", ex_b, 32'h7);
    chk("basic_ctr", 32'(ex_aluctr), 0);
    chk("basic_rd", 32'(ex_rd), 5);
    id_alusrc = 1'b1;
    id_imm = 32'hFFFF_FFFC;
    tick();
    chk("imm_b", ex_b, 32'hFFFF_FFFC);
    chk("imm_st", ex_st_data, 32'h7);
    set_id(1, 2, 3, 32'h5, 32'h7, ALU_ADD, 1, 0);
    tick();
    alu_out = 32'h11; mem_regwrite = 1'b1; mem_rd = 3; mem_data = 32'h22;
    set_id(3, 6, 7, 32'hAA, 32'hBB, ALU_ADD, 1, 0);
    tick();
    chk("fwd_ex_a", ex_a, 32'h11);
    chk("fwd_none_b", ex_b, 32'hBB);
    tick();
    chk("fwd_mem_a", ex_a, 32'h22);
    set_id(1, 2, 0, 32'h5, 32'h7, ALU_ADD, 1, 0);
    tick();
    chk("rd0_regwrite", 32'(ex_regwrite), 0);
    mem_rd = 0;
    set_id(0, 0, 8, 32'h33, 32'h44, ALU_ADD, 1, 0);
    tick();
    chk("rd0_nofwd_a", ex_a, 32'h33);
    chk("rd0_nofwd_b", ex_b, 32'h44);
    mem_regwrite = 1'b0;
    set_id(9, 9, 4, 32'h0, 32'h0, ALU_ADD, 1, 1);
    tick();
    chk("lw_memread", 32'(ex_memread), 1);
    set_id(4, 5, 6, 32'h1, 32'h2, ALU_SUB, 1, 0);
    #1 chk("lu_ready", 32'(id_ready), 0);
    tick();
    chk("lu_bubble", 32'(ex_valid), 0);
    chk("lu_bubble_ctl", 32'({ex_regwrite, ex_memread, ex_memwrite}), 0);
    chk("lu_stall", 32'(stall_cnt), 1);
    mem_regwrite = 1'b1; mem_rd = 4; mem_data = 32'h44;
    #1 chk("lu_ready2", 32'(id_ready), 1);
    tick();
    chk("lu_valid", 32'(ex_valid), 1);
    chk("lu_a", ex_a, 32'h44);
    chk("lu_b", ex_b, 32'h2);
    chk("lu_ctr", 32'(ex_aluctr), 32'(ALU_SUB));
    mem_regwrite = 1'b0;
    set_id(9, 9, 4, 32'h0, 32'h0, ALU_ADD, 1, 1);
    tick();
    set_id(4, 5, 6, 32'h1, 32'h2, ALU_SUB, 1, 0);
    id_uses_rs = 1'b0;
    #1 chk("nolu_ready", 32'(id_ready), 1);
    tick();
    chk("nolu_valid", 32'(ex_valid), 1);
    chk("nolu_a", ex_a, 32'h1);
    chk("nolu_stall", 32'(stall_cnt), 1);
    ex_ready = 1'b0;
    set_id(1, 2, 8, 32'h55, 32'h66, ALU_OR, 1, 0);
    mem_regwrite = 1'b1; mem_rd = 1;
    for (int i = 0; i < 3; i++) begin
      alu_out = 32'(i + 200);
      mem_data = 32'(i + 100);
      #1 chk("bp_ready", 32'(id_ready), 0);
      tick();
      chk("bp_a", ex_a, 32'h1);
      chk("bp_b", ex_b, 32'h2);
      chk("bp_valid", 32'(ex_valid), 1);
    end
    ex_ready = 1'b1;
    mem_regwrite = 1'b0;
    tick();
    chk("bp_release_a", ex_a, 32'h55);
    chk("bp_release_ctr", 32'(ex_aluctr), 32'(ALU_OR));
    set_id(9, 9, 4, 32'h0, 32'h0, ALU_ADD, 1, 1);
    tick();
    set_id(4, 5, 6, 32'h1, 32'h2, ALU_SUB, 1, 0);
    ex_ready = 1'b0;
    flush = 1'b1;
    #1 chk("flush_ready", 32'(id_ready), 1);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_stall", 32'(stall_cnt), 1);
    flush = 1'b0;
    ex_ready = 1'b1;
    set_id(1, 2, 5, 32'h5, 32'h7, ALU_ADD, 1, 0);
    tick();
    chk("post_flush_valid", 32'(ex_valid), 1);
    rst = 1'b1;
    #1 chk("midrst_ready", 32'(id_ready), 0);
    tick();
    chk("midrst_valid", 32'(ex_valid), 0);
    chk("midrst_a", ex_a, 0);
    chk("midrst_stall", 32'(stall_cnt), 0);
    rst = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
